// File: rtl/jtpopeye_dwnld_tx_if.sv
// ioctl download bus from the SPI download receiver to the ROM programming logic.
// Optional JTPOPEYE_DWNLD_CHKSUM_EN adds the running checksum signal.
interface jtpopeye_dwnld_tx_if #(
  parameter int AW    = 22,
  parameter int IDX_W = 8
);
  logic             downloading;
  logic [IDX_W-1:0] ioctl_index;
  logic [AW-1:0]    ioctl_addr;
  logic [7:0]       ioctl_data;
  logic             ioctl_wr;
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  logic [7:0]       chksum;

  modport master (output downloading, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, chksum);
  modport slave  (input  downloading, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, chksum);
`else
  modport master (output downloading, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr);
  modport slave  (input  downloading, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr);
`endif
endinterface

// File: rtl/jtpopeye_dwnld_tx.sv
// SPI file-transfer receiver driving the Popeye ioctl download bus (core clock domain).
// Optional JTPOPEYE_DWNLD_CHKSUM_EN: running 8-bit sum of written bytes on ioctl.chksum.
module jtpopeye_dwnld_tx #(
  parameter int AW    = 22,
  parameter int IDX_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_ss_n,
  input  logic spi_sck,
  input  logic spi_sdi,
  jtpopeye_dwnld_tx_if.master ioctl
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] IDX  = 3'd1;
  localparam logic [2:0] CTRL = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] SKIP = 3'd4;

  logic [1:0]       ss_q;
  logic [2:0]       sck_q;
  logic [1:0]       sdi_q;
  logic             ss_hi, sck_rise;

  logic [7:0]       sr_q, sr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             bdone_q, bdone_d;
  logic [7:0]       byte_q, byte_d;
  logic [2:0]       st_q, st_d;
  logic             dl_q, dl_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    acnt_q, acnt_d;
  logic [7:0]       data_q, data_d;
  logic             wr_q, wr_d;
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  assign ss_hi    = ss_q[1];
  assign sck_rise = sck_q[1] & ~sck_q[2];

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bdone_d = 1'b0;
    byte_d  = byte_q;
    st_d    = st_q;
    dl_d    = dl_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    acnt_d  = acnt_q;
    data_d  = data_q;
    wr_d    = 1'b0;
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    sum_d   = wr_q ? sum_q + data_q : sum_q;
`endif

    if (ss_hi) begin
      cnt_d = '0;
    end else if (sck_rise) begin
      sr_d  = {sr_q[6:0], sdi_q[1]};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        bdone_d = 1'b1;
        byte_d  = sr_d;
      end
    end

    // A registered byte_done landing in the same clk as the frame end is dropped
    if (ss_hi) begin
      st_d = IDLE;
    end else if (bdone_q) begin
      case (st_q)
        IDLE: begin
          case (byte_q)
            8'h53:   st_d = IDX;
            8'h54:   st_d = CTRL;
            8'h55:   st_d = DATA;
            default: st_d = SKIP;
          endcase
        end
        IDX: begin
          idx_d = IDX_W'(byte_q);
          st_d  = SKIP;
        end
        CTRL: begin
          if (byte_q == 8'hFF) begin
            dl_d   = 1'b1;
            acnt_d = '0;
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
            sum_d  = '0;
`endif
          end else if (byte_q == 8'h00) begin
            dl_d = 1'b0;
          end
          st_d = SKIP;
        end
        DATA: begin
          if (dl_q) begin
            data_d = byte_q;
            addr_d = acnt_q;
            wr_d   = 1'b1;
            acnt_d = acnt_q + AW'(1);
          end
        end
        default: st_d = SKIP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q    <= '1;
      sck_q   <= '0;
      sdi_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      bdone_q <= 1'b0;
      byte_q  <= '0;
      st_q    <= IDLE;
      dl_q    <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      acnt_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      ss_q    <= {ss_q[0], spi_ss_n};
      sck_q   <= {sck_q[1:0], spi_sck};
      sdi_q   <= {sdi_q[0], spi_sdi};
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bdone_q <= bdone_d;
      byte_q  <= byte_d;
      st_q    <= st_d;
      dl_q    <= dl_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      acnt_q  <= acnt_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign ioctl.downloading = dl_q;
  assign ioctl.ioctl_index = idx_q;
  assign ioctl.ioctl_addr  = addr_q;
  assign ioctl.ioctl_data  = data_q;
  assign ioctl.ioctl_wr    = wr_q;
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  assign ioctl.chksum      = sum_q;
`endif

endmodule

// File: tb/tb_jtpopeye_dwnld_tx.sv
// Bench for jtpopeye_dwnld_tx: frame table plus hand sequences, write scoreboard.
// A second instance with AW=2 exercises address wrap-around.
module tb_jtpopeye_dwnld_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss_n = 1'b1, sck = 1'b0, sdi = 1'b0, sel2 = 1'b0;
  logic ss1_n, ss2_n;

  assign ss1_n = sel2 | ss_n;
  assign ss2_n = ~sel2 | ss_n;

  always #5 clk = ~clk;

  jtpopeye_dwnld_tx_if #(.AW(22), .IDX_W(8)) io ();
  jtpopeye_dwnld_tx_if #(.AW(2),  .IDX_W(8)) io2 ();

  jtpopeye_dwnld_tx #(.AW(22), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .spi_ss_n(ss1_n), .spi_sck(sck), .spi_sdi(sdi), .ioctl(io)
  );
  jtpopeye_dwnld_tx #(.AW(2), .IDX_W(8)) dut2 (
    .clk(clk), .rst(rst), .spi_ss_n(ss2_n), .spi_sck(sck), .spi_sdi(sdi), .ioctl(io2)
  );

  typedef struct packed { logic [21:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    logic [63:0] b;
    int          n;
    logic        wr_en;
    logic [21:0] base;
    logic        exp_dl;
    logic [7:0]  exp_idx;
    logic [21:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  wr_t  q1[$], q2[$];
  vec_t vt[14];
  int   checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst && io.ioctl_wr) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_spurious actual addr=%0h data=%0h expected no write", io.ioctl_addr, io.ioctl_data);
      end else begin
        e = q1.pop_front();
        check("wr_addr", 32'(io.ioctl_addr), 32'(e.a));
        check("wr_data", 32'(io.ioctl_data), 32'(e.d));
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (!rst && io2.ioctl_wr) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr2_spurious actual addr=%0h data=%0h expected no write", io2.ioctl_addr, io2.ioctl_data);
      end else begin
        e = q2.pop_front();
        check("wr2_addr", 32'(io2.ioctl_addr), 32'(e.a));
        check("wr2_data", 32'(io2.ioctl_data), 32'(e.d));
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb);
    for (int i = 0; i < nb; i++) begin
      sdi = b[7-i];
      clks(3);
      sck = 1'b1;
      clks(3);
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [63:0] b, input int n);
    ss_n = 1'b0;
    clks(3);
    for (int k = 0; k < n; k++) send_bits(b[63-8*k -: 8], 8);
    clks(3);
    ss_n = 1'b1;
    clks(6);
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 40) begin
      clks(1);
      t++;
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d/%0d expected 0/0", q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dl"},   32'(io.downloading), 32'h0);
    check({tag, "_idx"},  32'(io.ioctl_index), 32'h0);
    check({tag, "_addr"}, 32'(io.ioctl_addr),  32'h0);
    check({tag, "_data"}, 32'(io.ioctl_data),  32'h0);
    check({tag, "_wr"},   32'(io.ioctl_wr),    32'h0);
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    check({tag, "_sum"},  32'(io.chksum),      32'h0);
`endif
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           bytes                                        n  wr    base   dl    idx    addr   data
    vt[0]  = '{{8'h53, 8'h02, 48'h0},                         2, 1'b0, 22'h0, 1'b0, 8'h02, 22'h0, 8'h00};
    vt[1]  = '{{8'h54, 8'hFF, 48'h0},                         2, 1'b0, 22'h0, 1'b1, 8'h02, 22'h0, 8'h00};
    vt[2]  = '{{8'h55, 8'hA5, 8'h3C, 8'h7E, 32'h0},           4, 1'b1, 22'h0, 1'b1, 8'h02, 22'h2, 8'h7E};
    vt[3]  = '{{8'h54, 8'h00, 48'h0},                         2, 1'b0, 22'h0, 1'b0, 8'h02, 22'h2, 8'h7E};
    vt[4]  = '{{8'h55, 8'h11, 8'h22, 40'h0},                  3, 1'b0, 22'h0, 1'b0, 8'h02, 22'h2, 8'h7E};
    vt[5]  = '{{8'h12, 8'h34, 48'h0},                         2, 1'b0, 22'h0, 1'b0, 8'h02, 22'h2, 8'h7E};
    vt[6]  = '{{8'h54, 8'hFF, 48'h0},                         2, 1'b0, 22'h0, 1'b1, 8'h02, 22'h2, 8'h7E};
    vt[7]  = '{{8'h55, 8'h01, 48'h0},                         2, 1'b1, 22'h0, 1'b1, 8'h02, 22'h0, 8'h01};
    vt[8]  = '{{8'h54, 8'hFF, 48'h0},                         2, 1'b0, 22'h0, 1'b1, 8'h02, 22'h0, 8'h01};
    vt[9]  = '{{8'h55, 8'h09, 8'h0A, 40'h0},                  3, 1'b1, 22'h0, 1'b1, 8'h02, 22'h1, 8'h0A};
    vt[10] = '{{8'h54, 8'h33, 48'h0},                         2, 1'b0, 22'h0, 1'b1, 8'h02, 22'h1, 8'h0A};
    vt[11] = '{{8'h55, 8'h0B, 48'h0},                         2, 1'b1, 22'h2, 1'b1, 8'h02, 22'h2, 8'h0B};
    vt[12] = '{{8'h53, 8'hFF, 8'h77, 40'h0},                  3, 1'b0, 22'h0, 1'b1, 8'hFF, 22'h2, 8'h0B};
    vt[13] = '{{8'h54, 8'h00, 48'h0},                         2, 1'b0, 22'h0, 1'b0, 8'hFF, 22'h2, 8'h0B};

    rst = 1'b1;
    clks(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    clks(2);

    // sck activity with the frame deselected must be ignored
    send_bits(8'hFF, 8);
    send_bits(8'h55, 8);
    clks(4);
    check("idle_dl", 32'(io.downloading), 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr_en)
        for (int k = 1; k < vt[i].n; k++)
          q1.push_back('{a: vt[i].base + 22'(k - 1), d: vt[i].b[63-8*k -: 8]});
      send_frame(vt[i].b, vt[i].n);
      drain();
      check($sformatf("v%0d_dl", i),   32'(io.downloading), 32'(vt[i].exp_dl));
      check($sformatf("v%0d_idx", i),  32'(io.ioctl_index), 32'(vt[i].exp_idx));
      check($sformatf("v%0d_addr", i), 32'(io.ioctl_addr),  32'(vt[i].exp_addr));
      check($sformatf("v%0d_data", i), 32'(io.ioctl_data),  32'(vt[i].exp_data));
    end

    // frame ends 5 bits into the second data byte
    send_frame({8'h54, 8'hFF, 48'h0}, 2);
    q1.push_back('{a: 22'h0, d: 8'hC3});
    ss_n = 1'b0;
    clks(3);
    send_bits(8'h55, 8);
    send_bits(8'hC3, 8);
    send_bits(8'hE7, 5);
    clks(3);
    ss_n = 1'b1;
    clks(6);
    drain();
    check("partial_addr", 32'(io.ioctl_addr), 32'h0);
    check("partial_data", 32'(io.ioctl_data), 32'hC3);
    send_frame({8'h53, 8'h44, 48'h0}, 2);
    check("after_partial_idx", 32'(io.ioctl_index), 32'h44);
    q1.push_back('{a: 22'h1, d: 8'h5A});
    send_frame({8'h55, 8'h5A, 48'h0}, 2);
    drain();
    check("cont_addr", 32'(io.ioctl_addr), 32'h1);

    // 8th sck rise and ss_n release arrive together: byte dropped
    ss_n = 1'b0;
    clks(3);
    send_bits(8'h55, 8);
    send_bits(8'h66, 7);
    sdi = 1'b0;
    clks(3);
    sck = 1'b1;
    ss_n = 1'b1;
    clks(3);
    sck = 1'b0;
    clks(6);
    drain();
    check("coinc_addr", 32'(io.ioctl_addr), 32'h1);
    check("coinc_data", 32'(io.ioctl_data), 32'h5A);

    // address wrap on the AW=2 instance
    sel2 = 1'b1;
    send_frame({8'h54, 8'hFF, 48'h0}, 2);
    check("wrap_dl", 32'(io2.downloading), 32'h1);
    q2.push_back('{a: 22'h0, d: 8'hA1});
    q2.push_back('{a: 22'h1, d: 8'hB2});
    q2.push_back('{a: 22'h2, d: 8'hC3});
    q2.push_back('{a: 22'h3, d: 8'hD4});
    q2.push_back('{a: 22'h0, d: 8'hE5});
    send_frame({8'h55, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 16'h0}, 6);
    drain();
    check("wrap_addr", 32'(io2.ioctl_addr), 32'h0);
    check("wrap_data", 32'(io2.ioctl_data), 32'hE5);
    sel2 = 1'b0;
    clks(4);
    check("wrap_other_data", 32'(io.ioctl_data), 32'h5A);

`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    send_frame({8'h54, 8'hFF, 48'h0}, 2);
    check("sum_start", 32'(io.chksum), 32'h0);
    q1.push_back('{a: 22'h0, d: 8'hF0});
    q1.push_back('{a: 22'h1, d: 8'h20});
    send_frame({8'h55, 8'hF0, 8'h20, 40'h0}, 3);
    drain();
    clks(2);
    check("sum_value", 32'(io.chksum), 32'h10);
    send_frame({8'h54, 8'hFF, 48'h0}, 2);
    check("sum_restart", 32'(io.chksum), 32'h0);
`endif

    // reset in the middle of a data frame
    send_frame({8'h54, 8'hFF, 48'h0}, 2);
    check("pre_rst_dl", 32'(io.downloading), 32'h1);
    ss_n = 1'b0;
    clks(3);
    send_bits(8'h55, 8);
    send_bits(8'h12, 4);
    rst = 1'b1;
    clks(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    send_bits(8'h34, 4);
    clks(3);
    ss_n = 1'b1;
    clks(6);
    send_frame({8'h55, 8'hAA, 8'hBB, 40'h0}, 3);
    drain();
    check("post_rst_dl", 32'(io.downloading), 32'h0);
    check("post_rst_addr", 32'(io.ioctl_addr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtpopeye_dwnld_tx.md
# jtpopeye_dwnld_tx

Download transmitter for the ROM-load path of the Popeye core. Receives the host's SPI file-transfer stream (MiST data_io style), decodes the command bytes, and drives the ioctl_addr / ioctl_data / ioctl_wr / downloading interface consumed by the PROM/SDRAM programming logic. It is the producer end of that ioctl byte stream and runs entirely in the core clock domain.

## Interface
- AW, 22, width of ioctl_addr
- IDX_W, 8, width of ioctl_index
- clk  in  1  core clock; reset is synchronous and active-high
- rst  in  1  synchronous reset, active-high
- spi_ss_n  in  1  frame select from host, async, active low
- spi_sck  in  1  SPI clock from host, async
- spi_sdi  in  1  SPI data, MSB first, valid on spi_sck rising edge
- downloading  out  1  high from download-start command to download-end command
- ioctl_index  out  IDX_W  file index set by host
- ioctl_addr  out  AW  byte address of current ioctl_data
- ioctl_data  out  8  received data byte
- ioctl_wr  out  1  one-clk write strobe

## Operation
- spi_ss_n, spi_sck, spi_sdi each pass a 2-flop synchronizer; spi_sck rising edge detected on the synchronized copies (edge = cur & ~prev).
- Shift register: on each sck rise with ss_n low, shift in sdi, increment 3-bit bit counter; count wrap 7→0 marks byte_done with the completed byte.
- Synchronized ss_n high: bit counter cleared, partial byte discarded, FSM → IDLE. ioctl_* and downloading are not touched.
- FSM states, advanced on byte_done:
  - IDLE: first byte of frame is the command. 0x53 → IDX; 0x54 → CTRL; 0x55 → DATA; any other → SKIP.
  - IDX: byte → ioctl_index; → SKIP.
  - CTRL: 0xFF → downloading=1, address counter=0; 0x00 → downloading=0; other values ignored; → SKIP.
  - DATA: each byte, only while downloading=1, produces a write; remains in DATA. Bytes while downloading=0 are dropped.
  - SKIP: bytes ignored until ss_n high.
- Write: ioctl_data ← byte, ioctl_addr ← address counter, ioctl_wr=1 for one clk; counter then increments. First write after start is at address 0.
- Address counter wraps 2^AW−1 → 0 silently.
- ioctl_addr/ioctl_data hold their last values between strobes and after downloading falls.
- Download start with downloading already 1 restarts the counter at 0.

## Timing
- Reset values: downloading 0, ioctl_index 0, ioctl_addr 0, ioctl_data 0, ioctl_wr 0, FSM IDLE, bit counter 0.
- Sync + edge detect latency: 3 clk from sck pin edge to shift.
- byte_done is registered; ioctl_wr asserts the clk after byte_done, with ioctl_addr/ioctl_data valid in that same clk. Total: 8th sck rise → ioctl_wr in 4–5 clk.
- downloading changes the clk after the CTRL argument's byte_done.
- Requirement on host: sck high and low phases each ≥ 3 clk; ss_n high ≥ 3 clk between frames.
- byte_done coinciding with synchronized ss_n rising: ss_n wins, byte discarded.
- rst mid-download: all outputs return to reset values next clk; later bytes need a fresh start command.

## Configuration
- JTPOPEYE_DWNLD_CHKSUM_EN defined: extra output `chksum` (8 bits, reset 0) is cleared on download start and adds ioctl_data (mod 256) on every ioctl_wr clk. The sum includes the byte written in that clk and is visible the following clk.
- Not defined: port and adder absent; remaining behaviour identical.

## Test plan
- Reset then idle: outputs all 0; toggle sck with ss_n high → no ioctl_wr, FSM stays IDLE.
- Frame 0x53,0x02 → ioctl_index=0x02; frame 0x54,0xFF → downloading=1.
- Frame 0x55,0xA5,0x3C,0x7E → three single-clk ioctl_wr pulses at addr 0,1,2 with data A5,3C,7E. Then frame 0x54,0x00 → downloading=0; ioctl_addr holds 2.
- Data frame with downloading=0 → no ioctl_wr. Frame 0x55 where ss_n rises after 5 bits of the second byte → exactly one write; next frame starts cleanly at IDLE.
- Preload counter to 0x3FFFFF (AW=22), send 2 data bytes → writes at 0x3FFFFF then 0x000000.
- With JTPOPEYE_DWNLD_CHKSUM_EN: start, then data 0xF0,0x20 → chksum 0x10. Restart → chksum 0. Assert rst mid-frame → downloading 0, chksum 0, no spurious wr.
